tl_source_tracker: RTL and testbench
====================================

Name: tl_source_tracker

Overview:
- Sits on a 32-bit TileLink-UL link directly upstream of the link's assertion monitor.
- Tracks outstanding requests per source ID from A/D handshakes and checks each response against its request.
- Emits registered error strobes and a sticky error flag; the monitor consumes these and raises fatal/printf.

Parameters:
SOURCE_BITS, 4, source ID width; tracks 2^SOURCE_BITS sources
SIZE_BITS, 4, width of a_size/d_size (log2 bytes)
TIMEOUT, 1024, watchdog limit in cycles (used only with TL_TRACKER_WATCHDOG_EN)

Ports:
clock  in  1  sole clock, all state on posedge
reset  in  1  synchronous, active-high
a_valid/a_ready  in  1/1  A channel handshake; fire = a_valid & a_ready
a_opcode  in  3  TL-UL A opcode
a_size  in  SIZE_BITS  log2 transfer bytes
a_source  in  SOURCE_BITS  request source ID
d_valid/d_ready  in  1/1  D channel handshake; fire = d_valid & d_ready
d_opcode  in  3  TL-UL D opcode
d_size  in  SIZE_BITS  response size
d_source  in  SOURCE_BITS  response source ID
err_reuse  out  1  pulse: A first beat on a source already in flight
err_unexpected  out  1  pulse: D first beat on a source not in flight
err_opcode  out  1  pulse: D opcode does not match expected response
err_size  out  1  pulse: d_size differs from recorded a_size
err_timeout  out  1  pulse: watchdog expiry (0 without feature)
err_sticky  out  1  OR of all strobes since reset
inflight_cnt  out  SOURCE_BITS+1  number of in-flight sources
idle  out  1  inflight_cnt==0 and both beat counters at first beat

Behaviour:
- Reset: all outputs 0, all in-flight bits 0, beat counters at first beat, watchdog 0.
- Beats: beats(size) = 1 if size<=2, else 1<<(size-2). A carries data for opcodes 0..3 (Put/PutPartial/Arith/Logical); Get(4) and Intent(5) are always 1 beat. D carries data only for AccessAckData(1).
- Beat counters for A and D each load beats-1 on a first-beat fire and decrement on each later fire. first = counter==0; last = first&&beats==1, or counter==1.
- A first-beat fire: set inflight[a_source]. Record exp_op[a_source] (0,1->AccessAck 0; 2,3,4->AccessAckData 1; 5->HintAck 2) and exp_size[a_source]=a_size.
- D first-beat fire: check inflight[d_source], d_opcode==exp_op, d_size==exp_size. If not in flight, raise err_unexpected only; suppress opcode/size checks.
- D last-beat fire: clear inflight[d_source].
- Same cycle, A first beat and D last beat on same source: clear takes effect before the A check, so there is no err_reuse and the bit ends set with the new record.
- Error strobes: registered, asserted exactly 1 cycle after the offending fire, 1 cycle wide. err_sticky sets the cycle after and holds until reset.
- inflight_cnt: updated +1/-1/0 per cycle from set/clear. Simultaneous set and clear gives net 0. Saturates at 2^SOURCE_BITS; never underflows, since a clear of a non-in-flight source is ignored.
- Mid-burst: non-first beats are not checked. A beats with a_valid low between them keep the counter.
- Reset mid-operation clears all tracking state; no error strobes fire on the reset cycle or the cycle after.

Optional Feature:
TL_TRACKER_WATCHDOG_EN
- Defined: a counter increments each cycle with inflight_cnt!=0 and no D fire. It clears on any D fire or when inflight_cnt==0.
- On reaching TIMEOUT-1 the block pulses err_timeout (registered, same 1-cycle rule), sets err_sticky, and restarts the counter from 0.
- Undefined: no counter logic; err_timeout tied to 0.

Decomposition:
- Package tl_tracker_pkg holds:
  - opcode localparams (PUT_FULL=0 ... INTENT=5; ACCESS_ACK=0, ACCESS_ACK_DATA=1, HINT_ACK=2)
  - function exp_resp(a_op)
  - function num_beats(size, has_data)
- One sub-module, tl_beat_counter, instantiated twice (A and D): inputs fire/size/has_data; outputs first/last.

Test Plan:
- Get src3 size2 fire, then AccessAckData src3 size2 two cycles later -> no errors; inflight_cnt 1 then 0; idle=1.
- PutFull src5 size4 (4 A beats), then a first beat on src5 before D -> err_reuse pulse 1 cycle after, err_sticky=1.
- D AccessAck src7 with nothing in flight -> err_unexpected only; err_opcode and err_size stay 0.
- Get src2 size3; D AccessAck size3 -> err_opcode. Repeat with AccessAckData size2 -> err_size only.
- Same cycle: Get src1 first beat plus last D beat for src1 -> no err_reuse; inflight_cnt unchanged; src1 still in flight.
- With TL_TRACKER_WATCHDOG_EN and TIMEOUT=16: Get src0 and no D for 16 cycles -> err_timeout pulse once. Without macro, same stimulus -> err_timeout stays 0.

Source files
------------

// File: rtl/tl_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tl_tracker_pkg
// Brief   : TileLink-UL opcode constants and helper functions shared by the
//           source tracker and its beat counters.
// Revision: 1.0 - initial release
// ============================================================================
package tl_tracker_pkg;

  // A channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITHMETIC  = 3'd2;
  localparam logic [2:0] LOGICAL     = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  // D channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] HINT_ACK        = 3'd2;

  // Response opcode a request is expected to receive
  function automatic logic [2:0] exp_resp(input logic [2:0] a_op);
    case (a_op)
      PUT_FULL, PUT_PARTIAL:    exp_resp = ACCESS_ACK;
      ARITHMETIC, LOGICAL, GET: exp_resp = ACCESS_ACK_DATA;
      INTENT:                   exp_resp = HINT_ACK;
      default:                  exp_resp = ACCESS_ACK;
    endcase
  endfunction

  // Beats in a message: one 4-byte beat per word when data is carried
  function automatic logic [31:0] num_beats(input logic [7:0] size, input logic has_data);
    if (!has_data || size <= 8'd2) num_beats = 32'd1;
    else                           num_beats = 32'd1 << (size - 8'd2);
  endfunction

  function automatic logic a_has_data(input logic [2:0] a_op);
    return a_op <= LOGICAL;
  endfunction

  function automatic logic d_has_data(input logic [2:0] d_op);
    return d_op == ACCESS_ACK_DATA;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_beat_counter.sv
`default_nettype none
// ============================================================================
// Module  : tl_beat_counter
// Brief   : Tracks position within a multi-beat TileLink message; reports the
//           first and last beat of the message currently on the channel.
// Revision: 1.0 - initial release
// ============================================================================
module tl_beat_counter
  import tl_tracker_pkg::*;
#(
  parameter int SIZE_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fire,
  input  logic [SIZE_BITS-1:0] size,
  input  logic                 has_data,
  output logic                 first,
  output logic                 last
);

  // Wide enough for beats-1 of the largest encodable size
  localparam int CNT_W = (2**SIZE_BITS > 32) ? 32 :
                         ((2**SIZE_BITS < 2) ? 2 : 2**SIZE_BITS);

  logic [31:0]      w_beats;
  logic [CNT_W-1:0] r_cnt;

  assign w_beats = num_beats(8'(size), has_data);
  assign first   = (r_cnt == '0);
  assign last    = (first && (w_beats == 32'd1)) || (r_cnt == CNT_W'(1));

  // Remaining-beats counter: load on a first-beat fire, count down after
  always_ff @(posedge clock) begin
    if (reset)      r_cnt <= '0;
    else if (fire)  r_cnt <= first ? (w_beats[CNT_W-1:0] - CNT_W'(1))
                                   : (r_cnt - CNT_W'(1));
  end

endmodule
`default_nettype wire

// File: rtl/tl_source_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tl_source_tracker
// Brief   : Per-source in-flight tracking on a TileLink-UL link; checks each
//           D response against its A request and raises error strobes.
//           Optional watchdog enabled by defining TL_TRACKER_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tl_source_tracker
  import tl_tracker_pkg::*;
#(
  parameter int SOURCE_BITS = 4,
  parameter int SIZE_BITS   = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_reuse,
  output logic                   err_unexpected,
  output logic                   err_opcode,
  output logic                   err_size,
  output logic                   err_timeout,
  output logic                   err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt,
  output logic                   idle
);

  localparam int NSRC = 2**SOURCE_BITS;

  // A watchdog limit below 2 cannot count
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("tl_source_tracker: TIMEOUT must be at least 2");
  end

  logic                   w_a_fire, w_d_fire;
  logic                   w_a_first, w_a_last_unused, w_d_first, w_d_last;
  logic                   w_set, w_clr, w_d_check, w_d_hit, w_a_busy, w_inc;
  logic                   w_reuse, w_unexp, w_opcode, w_size, w_timeout;
  logic [NSRC-1:0]        r_inflight;
  logic [2:0]             r_exp_op   [NSRC];
  logic [SIZE_BITS-1:0]   r_exp_size [NSRC];
  logic [SOURCE_BITS:0]   r_cnt;
  logic                   r_live;

  assign w_a_fire = a_valid & a_ready;
  assign w_d_fire = d_valid & d_ready;

  tl_beat_counter #(.SIZE_BITS(SIZE_BITS)) u_a_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (w_a_fire),
    .size     (a_size),
    .has_data (a_has_data(a_opcode)),
    .first    (w_a_first),
    .last     (w_a_last_unused)
  );

  tl_beat_counter #(.SIZE_BITS(SIZE_BITS)) u_d_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (w_d_fire),
    .size     (d_size),
    .has_data (d_has_data(d_opcode)),
    .first    (w_d_first),
    .last     (w_d_last)
  );

  // A clear retires the D source before the A reuse check sees it
  assign w_set     = w_a_fire & w_a_first;
  assign w_d_check = w_d_fire & w_d_first;
  assign w_d_hit   = r_inflight[d_source];
  assign w_clr     = w_d_fire & w_d_last & w_d_hit;
  assign w_a_busy  = r_inflight[a_source] & ~(w_clr & (d_source == a_source));
  assign w_inc     = w_set & ~w_a_busy;

  assign w_reuse  = w_set & w_a_busy;
  assign w_unexp  = w_d_check & ~w_d_hit;
  assign w_opcode = w_d_check & w_d_hit & (d_opcode != r_exp_op[d_source]);
  assign w_size   = w_d_check & w_d_hit & (d_size   != r_exp_size[d_source]);

`ifdef TL_TRACKER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] r_wd;
  logic            w_wd_run;

  assign w_wd_run  = (r_cnt != '0) && !w_d_fire;
  assign w_timeout = w_wd_run && (r_wd == WD_W'(TIMEOUT - 1));

  // Stall watchdog: runs while anything is outstanding and D is quiet
  always_ff @(posedge clock) begin
    if (reset || !w_wd_run || w_timeout) r_wd <= '0;
    else                                 r_wd <= r_wd + WD_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // In-flight bits; a set on the same source wins over a clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      if (w_clr) r_inflight[d_source] <= 1'b0;
      if (w_set) r_inflight[a_source] <= 1'b1;
    end
  end

  // Expected response record captured on each request's first beat
  always_ff @(posedge clock) begin
    if (w_set) begin
      r_exp_op[a_source]   <= exp_resp(a_opcode);
      r_exp_size[a_source] <= a_size;
    end
  end

  // Count of in-flight sources, saturating at both ends
  always_ff @(posedge clock) begin
    if (reset)
      r_cnt <= '0;
    else if (w_inc && !w_clr && (r_cnt != (SOURCE_BITS+1)'(NSRC)))
      r_cnt <= r_cnt + 1'b1;
    else if (!w_inc && w_clr && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  // Registered one-cycle error strobes and the sticky summary flag
  always_ff @(posedge clock) begin
    if (reset) begin
      err_reuse      <= 1'b0;
      err_unexpected <= 1'b0;
      err_opcode     <= 1'b0;
      err_size       <= 1'b0;
      err_timeout    <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      err_reuse      <= w_reuse;
      err_unexpected <= w_unexp;
      err_opcode     <= w_opcode;
      err_size       <= w_size;
      err_timeout    <= w_timeout;
      err_sticky     <= err_sticky | w_reuse | w_unexp | w_opcode | w_size | w_timeout;
    end
  end

  // Holds idle low while in reset so every output reads 0 there
  always_ff @(posedge clock) begin
    if (reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  assign inflight_cnt = r_cnt;
  assign idle         = r_live && (r_cnt == '0) && w_a_first && w_d_first;

endmodule
`default_nettype wire

// File: tb/tb_tl_source_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_tl_source_tracker
// Brief   : Self-checking vector bench for tl_source_tracker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tl_source_tracker;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACKD     = 3'd1;

  // Expected strobe patterns {reuse, unexpected, opcode, size, timeout}
  localparam int E0 = 5'b00000;
  localparam int ER = 5'b10000;
  localparam int EU = 5'b01000;
  localparam int EO = 5'b00100;
  localparam int ES = 5'b00010;
  localparam int ET = 5'b00001;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, d_valid, d_ready;
  logic [2:0] a_opcode, d_opcode;
  logic [3:0] a_size, a_source, d_size, d_source;
  logic       err_reuse, err_unexpected, err_opcode, err_size, err_timeout, err_sticky;
  logic [4:0] inflight_cnt;
  logic       idle;

  always #5 clock = ~clock;

  tl_source_tracker #(.SOURCE_BITS(4), .SIZE_BITS(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_size(d_size), .d_source(d_source),
    .err_reuse(err_reuse), .err_unexpected(err_unexpected),
    .err_opcode(err_opcode), .err_size(err_size), .err_timeout(err_timeout),
    .err_sticky(err_sticky), .inflight_cnt(inflight_cnt), .idle(idle)
  );

  typedef struct {
    logic       rst;
    logic       av, ar;
    logic [2:0] aop;
    logic [3:0] asz, asrc;
    logic       dv, dr;
    logic [2:0] dop;
    logic [3:0] dsz, dsrc;
    logic [4:0] err;
    logic       stk;
    logic [4:0] cnt;
    logic       idl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int rst, int av, int ar, int aop, int asz, int asrc,
                              int dv, int dr, int dop, int dsz, int dsrc,
                              int err, int stk, int cnt, int idl);
    vec_t v;
    v.rst = 1'(rst); v.av = 1'(av); v.ar = 1'(ar);
    v.aop = 3'(aop); v.asz = 4'(asz); v.asrc = 4'(asrc);
    v.dv = 1'(dv); v.dr = 1'(dr);
    v.dop = 3'(dop); v.dsz = 4'(dsz); v.dsrc = 4'(dsrc);
    v.err = 5'(err); v.stk = 1'(stk); v.cnt = 5'(cnt); v.idl = 1'(idl);
    return v;
  endfunction

  function automatic vec_t vr();
    return mk(1, 0,0,0,0,0, 0,0,0,0,0, E0,0,0,0);
  endfunction
  function automatic vec_t vn(int err, int stk, int cnt, int idl);
    return mk(0, 0,1,0,0,0, 0,1,0,0,0, err,stk,cnt,idl);
  endfunction
  function automatic vec_t va(int op, int sz, int src, int err, int stk, int cnt, int idl);
    return mk(0, 1,1,op,sz,src, 0,1,0,0,0, err,stk,cnt,idl);
  endfunction
  function automatic vec_t vd(int op, int sz, int src, int err, int stk, int cnt, int idl);
    return mk(0, 0,1,0,0,0, 1,1,op,sz,src, err,stk,cnt,idl);
  endfunction
  function automatic vec_t vad(int aop, int asz, int asrc, int dop, int dsz, int dsrc,
                               int err, int stk, int cnt, int idl);
    return mk(0, 1,1,aop,asz,asrc, 1,1,dop,dsz,dsrc, err,stk,cnt,idl);
  endfunction

  // Idle cycle i after a lone Get with a 16-cycle watchdog limit
  function automatic vec_t wd_vec(int i);
    int to;
    int stk;
    to  = 0;
    stk = 0;
`ifdef TL_TRACKER_WATCHDOG_EN
    to  = (i == 16) ? ET : E0;
    stk = (i >= 16) ? 1 : 0;
`endif
    return vn(to, stk, 1, 0);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    reset    = v.rst;
    a_valid  = v.av;  a_ready = v.ar;  a_opcode = v.aop;
    a_size   = v.asz; a_source = v.asrc;
    d_valid  = v.dv;  d_ready = v.dr;  d_opcode = v.dop;
    d_size   = v.dsz; d_source = v.dsrc;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("err_strobes", n_vec,
          int'({err_reuse, err_unexpected, err_opcode, err_size, err_timeout}), int'(e.err));
    check("err_sticky", n_vec, int'(err_sticky), int'(e.stk));
    check("inflight_cnt", n_vec, int'(inflight_cnt), int'(e.cnt));
    check("idle", n_vec, int'(idle), int'(e.idl));
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_valid = 0; a_ready = 0; a_opcode = 0; a_size = 0; a_source = 0;
    d_valid = 0; d_ready = 0; d_opcode = 0; d_size = 0; d_source = 0;

    // Reset state
    tbl.push_back(vr());
    tbl.push_back(vr());
    // Get src3 size2, AccessAckData two cycles later; stalled A does not fire
    tbl.push_back(va(OP_GET, 2, 3,        E0,0,1,0));
    tbl.push_back(vn(                     E0,0,1,0));
    tbl.push_back(vd(OP_ACKD, 2, 3,       E0,0,0,1));
    tbl.push_back(mk(0, 1,0,OP_GET,2,9, 0,1,0,0,0, E0,0,0,1));
    // PutFull src5 size4 = 4 beats with a gap, then a new first beat on src5
    tbl.push_back(va(OP_PUT_FULL, 4, 5,   E0,0,1,0));
    tbl.push_back(va(OP_PUT_FULL, 4, 5,   E0,0,1,0));
    tbl.push_back(vn(                     E0,0,1,0));
    tbl.push_back(va(OP_PUT_FULL, 4, 5,   E0,0,1,0));
    tbl.push_back(va(OP_PUT_FULL, 4, 5,   E0,0,1,0));
    tbl.push_back(va(OP_GET, 2, 5,        ER,1,1,0));
    tbl.push_back(vn(                     E0,1,1,0));
    // Reset mid-operation, then response with nothing in flight
    tbl.push_back(vr());
    tbl.push_back(vd(OP_ACK, 2, 7,        EU,1,0,1));
    tbl.push_back(vn(                     E0,1,0,1));
    tbl.push_back(vr());
    // Wrong opcode, then wrong size
    tbl.push_back(va(OP_GET, 3, 2,        E0,0,1,0));
    tbl.push_back(vd(OP_ACK, 3, 2,        EO,1,0,1));
    tbl.push_back(va(OP_GET, 3, 2,        E0,1,1,0));
    tbl.push_back(vd(OP_ACKD, 2, 2,       ES,1,0,1));
    // Two-beat response retires the source only on its last beat
    tbl.push_back(va(OP_GET, 3, 6,        E0,1,1,0));
    tbl.push_back(vd(OP_ACKD, 3, 6,       E0,1,1,0));
    tbl.push_back(vd(OP_ACKD, 3, 6,       E0,1,0,1));
    tbl.push_back(vr());
    // Same-cycle reissue on src1 while its response completes
    tbl.push_back(va(OP_GET, 2, 1,        E0,0,1,0));
    tbl.push_back(vad(OP_GET, 2, 1, OP_ACKD, 2, 1, E0,0,1,0));
    tbl.push_back(vd(OP_ACKD, 2, 1,       E0,0,0,1));
    tbl.push_back(vn(                     E0,0,0,1));
    // Several sources outstanding; set and clear of different sources
    tbl.push_back(va(OP_GET, 2, 8,        E0,0,1,0));
    tbl.push_back(va(OP_GET, 2, 9,        E0,0,2,0));
    tbl.push_back(vad(OP_PUT_FULL, 2, 10, OP_ACKD, 2, 8, E0,0,2,0));
    tbl.push_back(vd(OP_ACK, 2, 10,       E0,0,1,0));
    tbl.push_back(vd(OP_ACKD, 2, 9,       E0,0,0,1));

    foreach (tbl[i]) apply(tbl[i]);

    // Watchdog: a Get left unanswered
    apply(vr());
    apply(va(OP_GET, 2, 0, E0,0,1,0));
    for (int i = 1; i <= 24; i++) apply(wd_vec(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
